// File: rtl/yasac_run_ctrl.sv
// Run controller for one YASAC processor: launch, instruction/cycle counting, budget and abort.
// Optional watchdog (status 11) is built only when YASAC_RUN_CTRL_WDOG_EN is defined.
module yasac_run_ctrl #(
   parameter logic [1:0]  FETCH_STATE = 2'd1,
   parameter logic [15:0] WDOG_CYCLES = 16'd1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run_valid,
   input  logic [15:0] run_limit,
   output logic        run_ready,
   input  logic        abort,
   output logic        cpu_start,
   output logic        cpu_reset,
   input  logic        cpu_ready,
   input  logic [1:0]  cpu_state,
   output logic        busy,
   output logic        done,
   output logic [1:0]  status,
   output logic [15:0] icount,
   output logic [15:0] ccount
);

   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RUN, S_STOP, S_DONE} state_t;

   localparam logic [1:0] ST_COMPLETE = 2'b00;
   localparam logic [1:0] ST_LIMIT    = 2'b01;
   localparam logic [1:0] ST_ABORT    = 2'b10;
   localparam logic [1:0] ST_TIMEOUT  = 2'b11;

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_status, w_status_nxt;
   logic [1:0]  r_prev_state;
   logic [15:0] r_limit, w_limit_nxt;
   logic [15:0] r_icount, w_icount_nxt, w_icount_inc;
   logic [15:0] r_ccount, w_ccount_nxt, w_ccount_inc;
   logic        r_cpu_start, r_cpu_reset, r_done;
   logic        w_fetch_entry, w_limit_hit, w_wdog_hit;

   assign w_fetch_entry = (cpu_state == FETCH_STATE) && (r_prev_state != FETCH_STATE);
   assign w_limit_hit   = w_fetch_entry && (r_limit != '0) && (r_icount == r_limit);
   assign w_icount_inc  = (r_icount == '1) ? r_icount : r_icount + 16'd1;
   assign w_ccount_inc  = (r_ccount == '1) ? r_ccount : r_ccount + 16'd1;

`ifdef YASAC_RUN_CTRL_WDOG_EN
   logic [15:0] r_wdog;
   logic [15:0] w_wdog_inc;

   assign w_wdog_inc = r_wdog + 16'd1;
   // Timeout fires on the cycle whose increment would reach the limit.
   assign w_wdog_hit = ((r_state == S_WAIT) || ((r_state == S_RUN) && !w_fetch_entry)) &&
                       (w_wdog_inc == WDOG_CYCLES);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wdog <= '0;
      end else begin
         case (r_state)
            S_IDLE:  r_wdog <= '0;
            S_WAIT:  r_wdog <= w_wdog_inc;
            S_RUN:   r_wdog <= w_fetch_entry ? '0 : w_wdog_inc;
            default: r_wdog <= r_wdog;
         endcase
      end
   end
`else
   logic [15:0] w_unused_wdog;

   assign w_unused_wdog = WDOG_CYCLES;
   assign w_wdog_hit    = 1'b0;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_status_nxt = r_status;
      w_limit_nxt  = r_limit;
      w_icount_nxt = r_icount;
      w_ccount_nxt = r_ccount;
      case (r_state)
         S_IDLE: begin
            if (run_valid) begin
               w_state_nxt  = S_LAUNCH;
               w_status_nxt = ST_COMPLETE;
               w_limit_nxt  = run_limit;
               w_icount_nxt = '0;
               w_ccount_nxt = '0;
            end
         end
         S_LAUNCH: begin
            w_ccount_nxt = w_ccount_inc;
            w_state_nxt  = S_WAIT;
         end
         S_WAIT: begin
            w_ccount_nxt = w_ccount_inc;
            if (abort) begin
               w_state_nxt  = S_STOP;
               w_status_nxt = ST_ABORT;
            end else if (w_wdog_hit) begin
               w_state_nxt  = S_STOP;
               w_status_nxt = ST_TIMEOUT;
            end else if (!cpu_ready) begin
               w_state_nxt  = S_RUN;
            end
         end
         S_RUN: begin
            w_ccount_nxt = w_ccount_inc;
            if (abort) begin
               w_state_nxt  = S_STOP;
               w_status_nxt = ST_ABORT;
            end else if (cpu_ready) begin
               w_state_nxt  = S_DONE;
               w_status_nxt = ST_COMPLETE;
            end else if (w_limit_hit) begin
               w_state_nxt  = S_STOP;
               w_status_nxt = ST_LIMIT;
            end else if (w_wdog_hit) begin
               w_state_nxt  = S_STOP;
               w_status_nxt = ST_TIMEOUT;
            end else if (w_fetch_entry) begin
               w_icount_nxt = w_icount_inc;
            end
         end
         S_STOP:  w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_status     <= ST_COMPLETE;
         r_prev_state <= '0;
         r_limit      <= '0;
         r_icount     <= '0;
         r_ccount     <= '0;
         r_cpu_start  <= 1'b0;
         r_cpu_reset  <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_status     <= w_status_nxt;
         r_prev_state <= cpu_state;
         r_limit      <= w_limit_nxt;
         r_icount     <= w_icount_nxt;
         r_ccount     <= w_ccount_nxt;
         r_cpu_start  <= (w_state_nxt == S_LAUNCH);
         r_cpu_reset  <= (w_state_nxt == S_STOP);
         r_done       <= (w_state_nxt == S_DONE);
      end
   end

   assign run_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign cpu_start = r_cpu_start;
   assign cpu_reset = r_cpu_reset;
   assign done      = r_done;
   assign status    = r_status;
   assign icount    = r_icount;
   assign ccount    = r_ccount;

endmodule

// File: doc/yasac_run_ctrl.md
# yasac_run_ctrl

Run controller that sequences one YASAC processor through its `start`/`ready` handshake on behalf of a host (testbench, debug UART or board buttons). It launches a program, counts executed instructions and clock cycles, and enforces an optional instruction budget. It aborts the run by pulsing the processor's synchronous reset on host request, on budget exhaustion or on a watchdog timeout. It sits beside the processor top level: its outputs drive the processor's `start` and `reset`, and it observes `ready` and `state_out`.

## Interface
Parameters:
- `FETCH_STATE`, default 2'd1: encoding of the processor FSM fetch state on `state_out`.
- `WDOG_CYCLES`, default 16'd1000: maximum cycles allowed without a fetch entry.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `run_valid` in 1: host requests a run.
- `run_limit` in 16: instruction budget; 0 means unlimited. Sampled on acceptance.
- `run_ready` out 1: controller can accept a run (high only in IDLE).
- `abort` in 1: level; requests termination of the current run.
- `cpu_start` out 1: drives processor `start`.
- `cpu_reset` out 1: drives processor `reset` (synchronous, active-high).
- `cpu_ready` in 1: processor `ready`.
- `cpu_state` in 2: processor `state_out`.
- `busy` out 1: run in progress (any state except IDLE).
- `done` out 1: one-cycle pulse at end of run.
- `status` out 2: result of last run. 00 completed, 01 limit, 10 aborted, 11 timeout.
- `icount` out 16: instructions fetched in current/last run, saturating at 16'hFFFF.
- `ccount` out 16: cycles since launch in current/last run, saturating at 16'hFFFF.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RUN, STOP, DONE.
- IDLE:
  - `run_ready`=1.
  - `run_valid` accepted: latch `run_limit`; clear `icount`, `ccount`, watchdog counter; go to LAUNCH.
- LAUNCH: `cpu_start`=1 for exactly this cycle; go to WAIT.
- WAIT: wait for `cpu_ready`=0, then go to RUN. `abort` and watchdog are active here.
- RUN:
  - Fetch entry = `cpu_state`==`FETCH_STATE` while the registered previous `cpu_state`!=`FETCH_STATE`.
  - On fetch entry with limit!=0 and `icount`==limit: go to STOP with status 01; `icount` is not incremented.
  - On any other fetch entry: `icount`+1 and watchdog counter cleared.
  - `cpu_ready`=1: go to DONE with status 00.
- Same-cycle priority in WAIT/RUN: abort > completion (`cpu_ready`) > limit > timeout.
- Watchdog counter increments every WAIT/RUN cycle without a fetch entry. On reaching `WDOG_CYCLES`: go to STOP with status 11.
- STOP: `cpu_reset`=1 for exactly one cycle; go to DONE.
- DONE: `done`=1 for one cycle; go to IDLE.
- `status`, `icount` and `ccount` hold their values until the next run is accepted.
- `ccount` increments in every LAUNCH, WAIT and RUN cycle.
- `abort` while IDLE, STOP or DONE is ignored.
- `run_valid` outside IDLE is ignored (not queued).

## Timing
- Reset values: state IDLE; `run_ready`=1; `cpu_start`=0, `cpu_reset`=0, `busy`=0, `done`=0; `status`=00; `icount`=0, `ccount`=0. Reset mid-run returns to IDLE immediately, with no `cpu_reset` pulse and no `done`.
- All outputs are registered except `run_ready` and `busy`, which decode the state.
- Acceptance at edge N: `cpu_start` high in cycle N+1, `busy` high from N+1.
- Stop decision at edge M: `cpu_reset` high in cycle M+1, `done` high in cycle M+2, `run_ready` high in cycle M+3.
- Completion at edge M: `done` high in cycle M+1.
- Back-to-back runs: a new run can be accepted in the first cycle after `done`.

## Configuration
- `YASAC_RUN_CTRL_WDOG_EN` defined: watchdog counter and status 11 are present, as described above.
- Not defined:
  - Watchdog logic is removed and `WDOG_CYCLES` is unused.
  - Status 11 is never produced.
  - A hung run ends only by `abort`, limit or completion.

## Test plan
- Reset mid-RUN (`icount`=5) -> IDLE, `run_ready`=1, `icount`=0, no `done`, no `cpu_reset` pulse.
- Run with limit 0; processor executes 12 instructions then raises `ready` -> one-cycle `done`, status 00, `icount`=12, `cpu_reset` never asserted.
- Run with limit 3 on an endless loop -> 4th fetch entry triggers a one-cycle `cpu_reset`, then `done`; status 01, `icount`=3.
- `abort` raised 20 cycles after launch, in the same cycle as `cpu_ready` rising -> status 10, `cpu_reset` pulse, `done`.
- `WDOG_CYCLES`=8 with `cpu_state` frozen (macro defined) -> status 11 eight cycles after the last fetch entry. With the macro undefined: `busy` stays high until `abort`.
- `run_valid` held high across `done` -> second run accepted the cycle after `done`, counters cleared, `cpu_start` pulsed again.
